// File: rtl/pc_sequencer.sv
// Program sequencer: fetch/decode/execute FSM, flag-conditional branches and a CALL/RET return stack.
// Define STACK_ERR_HALT_EN to halt on stack overflow/underflow instead of stepping past the faulting CALL/RET.
module pc_sequencer #(
  parameter  int PC_W        = 8,
  parameter  int INSTR_W     = 32,
  parameter  int STACK_DEPTH = 4,
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] crnt_instrn,
  input  logic               zro_flag,
  input  logic               carry_flag,
  input  logic               neg_flag,
  output logic               instr_req,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         current_state,
  output logic [CNT_W-1:0]   stk_cnt,
  output logic               stk_err,
  output logic               halted
);

  localparam int              IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] STK_FULL = CNT_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Opcodes 8-15 are not enumerated; they fall through to the NOP path.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_JMP  = 4'd1,
    OP_JZ   = 4'd2,
    OP_JC   = 4'd3,
    OP_JN   = 4'd4,
    OP_CALL = 4'd5,
    OP_RET  = 4'd6,
    OP_HALT = 4'd7
  } op_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  op_t                op_q, op_d;
  logic [CNT_W-1:0]   stk_cnt_q, stk_cnt_d;
  logic               stk_err_q, stk_err_d;

  logic [PC_W-1:0]    stack_q [STACK_DEPTH];
  logic               push_en;
  logic               stk_fault;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    imm;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  assign pc_inc   = pc_q + PC_W'(1);
  assign imm      = ir_q[PC_W-1:0];
  assign push_idx = IDX_W'(stk_cnt_q);
  assign pop_idx  = IDX_W'(stk_cnt_q - CNT_W'(1));

  // Middle instruction bits carry no meaning for the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[INSTR_W-5:PC_W];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    op_d      = op_q;
    stk_cnt_d = stk_cnt_q;
    stk_err_d = stk_err_q;
    push_en   = 1'b0;
    stk_fault = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = crnt_instrn;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d    = op_t'(ir_q[INSTR_W-1 -: 4]);
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_JMP: pc_d = imm;
          OP_JZ:  pc_d = zro_flag   ? imm : pc_inc;
          OP_JC:  pc_d = carry_flag ? imm : pc_inc;
          OP_JN:  pc_d = neg_flag   ? imm : pc_inc;
          OP_CALL: begin
            if (stk_cnt_q == STK_FULL) begin
              stk_fault = 1'b1;
            end else begin
              push_en   = 1'b1;
              stk_cnt_d = stk_cnt_q + CNT_W'(1);
              pc_d      = imm;
            end
          end
          OP_RET: begin
            if (stk_cnt_q == '0) begin
              stk_fault = 1'b1;
            end else begin
              stk_cnt_d = stk_cnt_q - CNT_W'(1);
              pc_d      = stack_q[pop_idx];
            end
          end
          OP_HALT: state_d = S_HALT;
          default: pc_d = pc_inc;
        endcase

        if (stk_fault) begin
          stk_err_d = 1'b1;
`ifdef STACK_ERR_HALT_EN
          state_d   = S_HALT;
`else
          pc_d      = pc_inc;
`endif
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      op_q      <= OP_NOP;
      stk_cnt_q <= '0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      op_q      <= op_d;
      stk_cnt_q <= stk_cnt_d;
      stk_err_q <= stk_err_d;
    end
  end

  // NOTE: the stack array is not reset; entries at or above stk_cnt are never read, so clearing the count suffices.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign instr_req     = (state_q == S_FETCH);
  assign halted        = (state_q == S_HALT);
  assign current_state = state_q;
  assign pc            = pc_q;
  assign stk_cnt       = stk_cnt_q;
  assign stk_err       = stk_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each retired instruction,
// and a monitor compares whenever the DUT leaves S_EXEC.
module tb_pc_sequencer;

  localparam int PC_W        = 8;
  localparam int INSTR_W     = 32;
  localparam int STACK_DEPTH = 4;
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1);
  localparam int PC_MOD      = 1 << PC_W;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               instr_valid = 1'b0;
  logic [INSTR_W-1:0] crnt_instrn = '0;
  logic               zro_flag = 1'b0;
  logic               carry_flag = 1'b0;
  logic               neg_flag = 1'b0;
  logic               instr_req;
  logic [PC_W-1:0]    pc;
  logic [2:0]         current_state;
  logic [CNT_W-1:0]   stk_cnt;
  logic               stk_err;
  logic               halted;

  pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .crnt_instrn   (crnt_instrn),
    .zro_flag      (zro_flag),
    .carry_flag    (carry_flag),
    .neg_flag      (neg_flag),
    .instr_req     (instr_req),
    .pc            (pc),
    .current_state (current_state),
    .stk_cnt       (stk_cnt),
    .stk_err       (stk_err),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int cnt;
    int err;
    int halt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: program counter, return-address list, sticky error, halt flag.
  int   m_pc;
  int   m_stk[$];
  bit   m_err;
  bit   m_halt;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc   = 0;
    m_stk.delete();
    m_err  = 1'b0;
    m_halt = 1'b0;
  endfunction

  function automatic void model_step(input int op, input int imm, input bit z, input bit c, input bit n);
    int nxt   = (m_pc + 1) % PC_MOD;
    bit fault = 1'b0;
    case (op)
      1: m_pc = imm;
      2: m_pc = z ? imm : nxt;
      3: m_pc = c ? imm : nxt;
      4: m_pc = n ? imm : nxt;
      5: begin
        if (m_stk.size() >= STACK_DEPTH) fault = 1'b1;
        else begin
          m_stk.push_back(nxt);
          m_pc = imm;
        end
      end
      6: begin
        if (m_stk.size() == 0) fault = 1'b1;
        else m_pc = m_stk.pop_back();
      end
      7: m_halt = 1'b1;
      default: m_pc = nxt;
    endcase
    if (fault) begin
      m_err = 1'b1;
`ifdef STACK_ERR_HALT_EN
      m_halt = 1'b1;
`else
      m_pc = nxt;
`endif
    end
    sb_q.push_back('{m_pc, m_stk.size(), int'(m_err), int'(m_halt)});
  endfunction

  // Monitor: an instruction retires when the FSM leaves S_EXEC.
  logic [2:0] prev_state = 3'd0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && prev_state == 3'd3 && (current_state == 3'd1 || current_state == 3'd4)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_retire", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("retire_pc", pc, e.pc);
        check("retire_stk_cnt", stk_cnt, e.cnt);
        check("retire_stk_err", stk_err, e.err);
        check("retire_halted", halted, e.halt);
        check("retire_state", current_state, e.halt ? 4 : 1);
      end
    end
    prev_state = current_state;
  end

  // Called on a falling edge: asserts reset, checks the cleared state, then releases it.
  task automatic do_reset();
    reset       = 1'b0;
    instr_valid = 1'b0;
    sb_q.delete();
    model_reset();
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_state", current_state, 0);
    check("rst_stk_cnt", stk_cnt, 0);
    check("rst_stk_err", stk_err, 0);
    check("rst_halted", halted, 0);
    check("rst_instr_req", instr_req, 0);
    reset = 1'b1;
    #1;
    check("release_state0", current_state, 0);
    @(negedge clk);
    check("release_state1", current_state, 1);
    check("release_instr_req", instr_req, 1);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!instr_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch_wait", instr_req, 1);
  endtask

  task automatic drive_instr(input int op, input int imm, input bit z, input bit c, input bit n);
    instr_valid = 1'b1;
    crnt_instrn = $urandom;
    crnt_instrn[INSTR_W-1 -: 4] = op[3:0];
    crnt_instrn[PC_W-1:0]       = imm[PC_W-1:0];
    zro_flag   = z;
    carry_flag = c;
    neg_flag   = n;
  endtask

  task automatic halt_hold();
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'($urandom);
      @(negedge clk);
      check("halt_state", current_state, 4);
      check("halt_flag", halted, 1);
      check("halt_instr_req", instr_req, 0);
      check("halt_pc", pc, m_pc);
      check("halt_stk_cnt", stk_cnt, m_stk.size());
    end
    do_reset();
  endtask

  task automatic run_instr(input int op, input int imm, input bit z, input bit c, input bit n, input int stall);
    int lat;
    wait_fetch();
    for (int i = 0; i < stall; i++) begin
      instr_valid = 1'b0;
      crnt_instrn = $urandom;
      {zro_flag, carry_flag, neg_flag} = 3'($urandom);
      @(negedge clk);
      check("stall_state", current_state, 1);
      check("stall_pc", pc, m_pc);
    end
    drive_instr(op, imm, z, c, n);
    model_step(op, imm, z, c, n);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!instr_req && !halted && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    if (m_halt) halt_hold();
  endtask

  task automatic reset_mid_decode();
    wait_fetch();
    drive_instr(5, 'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    check("pre_abort_state", current_state, 2);
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();

    // Stalled fetch followed by a NOP.
    run_instr(0, 'h33, 1'b0, 1'b0, 1'b0, 5);

    // Conditional branches taken and not taken; the other two flags are set opposite.
    for (int op = 2; op <= 4; op++) begin
      for (int taken = 0; taken < 2; taken++) begin
        bit f = 1'(taken);
        do_reset();
        run_instr(op, 'h40, (op == 2) ? f : ~f, (op == 3) ? f : ~f, (op == 4) ? f : ~f, 0);
      end
    end

    // Call/return, including the wrap of the return address.
    do_reset();
    run_instr(1, 'h05, 1'b0, 1'b0, 1'b0, 1);
    run_instr(5, 'h20, 1'b0, 1'b0, 1'b0, 0);
    run_instr(6, 'h99, 1'b0, 1'b0, 1'b0, 2);
    run_instr(1, 'hFF, 1'b0, 1'b0, 1'b0, 0);
    run_instr(5, 'h30, 1'b0, 1'b0, 1'b0, 0);
    run_instr(6, 'h00, 1'b0, 1'b0, 1'b0, 0);

    // Reset while a CALL sits in decode, with a non-empty stack and non-zero pc.
    run_instr(1, 'h77, 1'b0, 1'b0, 1'b0, 0);
    run_instr(5, 'h10, 1'b0, 1'b0, 1'b0, 0);
    reset_mid_decode();

    // Overflow on the fifth CALL, then drain and underflow.
    for (int i = 0; i < STACK_DEPTH + 1; i++)
      run_instr(5, int'($urandom_range(0, PC_MOD - 1)), 1'b0, 1'b0, 1'b0, 0);
    while (m_stk.size() > 0)
      run_instr(6, 0, 1'b0, 1'b0, 1'b0, 0);
    run_instr(6, 'h12, 1'b0, 1'b0, 1'b0, 0);

    // Explicit HALT.
    run_instr(1, 'hA0, 1'b0, 1'b0, 1'b0, 0);
    run_instr(7, 'h01, 1'b1, 1'b1, 1'b1, 0);

    // Random instruction stream; CALL and RET are favoured to exercise the stack.
    for (int i = 0; i < 250; i++) begin
      int r  = int'($urandom_range(0, 19));
      int op = (r >= 16) ? ((r < 18) ? 5 : 6) : r;
      run_instr(op, int'($urandom_range(0, PC_MOD - 1)), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
